// File: rtl/cache_io_pkg.sv
// Shared FSM encoding, bus width defaults and timer sizing helper for the cache IO config master.
package cache_io_pkg;

   localparam int CACHE_IO_ADDR_W = 32;
   localparam int CACHE_IO_DATA_W = 32;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CMD    = 2'd1;
   localparam logic [1:0] ST_RDWAIT = 2'd2;
   localparam logic [1:0] ST_RSP    = 2'd3;

   // Counter only needs to reach TIMEOUT_CYC-2 before the expiry decision is taken.
   function automatic int tmo_cnt_w(input int cyc);
      return (cyc > 2) ? $clog2(cyc) : 1;
   endfunction

endpackage

// File: rtl/cache_io_cfg_timer.sv
// Read-response watchdog: counts cycles while run_i is high, clears when it drops.
// expired_o fires in the cycle whose closing edge would bring the count to TIMEOUT_CYC-1.
module cache_io_cfg_timer
   import cache_io_pkg::*;
#(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic clk,
   input  logic rest,
   input  logic run_i,
   output logic expired_o
);

   localparam int            CW   = tmo_cnt_w(TIMEOUT_CYC);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 2);

   logic [CW-1:0] cnt_q, cnt_d;

   assign cnt_d     = run_i ? cnt_q + CW'(1) : '0;
   assign expired_o = run_i && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (rest) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cache_io_cfg_master.sv
// Avalon-MM initiator for the cache IO-region s0 port; one request in flight, req->m0 command 1 cycle.
// req_ready only in IDLE, rsp is a one-cycle pulse; CACHE_IO_CFG_TIMEOUT_EN adds a read-response timeout.
module cache_io_cfg_master
   import cache_io_pkg::*;
#(
   parameter int ADDR_W      = CACHE_IO_ADDR_W,
   parameter int DATA_W      = CACHE_IO_DATA_W,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rest,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [3:0]        req_be,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] m0_address,
   output logic [3:0]        m0_byteEnable,
   output logic              m0_read,
   output logic              m0_write,
   output logic [DATA_W-1:0] m0_writeData,
   input  logic [DATA_W-1:0] m0_readData,
   input  logic              m0_waitRequest,
   input  logic              m0_readDataValid
);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_d;
   logic              tmo_expired;

`ifdef CACHE_IO_CFG_TIMEOUT_EN
   logic err_q;

   cache_io_cfg_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk       (clk),
      .rest      (rest),
      .run_i     (state_q == ST_RDWAIT),
      .expired_o (tmo_expired)
   );

   assign rsp_err = (state_q == ST_RSP) && err_q;
`else
   logic unused_tmo;

   assign tmo_expired = 1'b0;
   assign unused_tmo  = (TIMEOUT_CYC == 0) | err_d;
   assign rsp_err     = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      write_d = write_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;
`ifdef CACHE_IO_CFG_TIMEOUT_EN
      err_d   = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               be_d    = req_be;
               write_d = req_write;
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = ST_CMD;
            end
         end
         ST_CMD: begin
            if (!m0_waitRequest) begin
               if (write_q) begin
                  state_d = ST_RSP;
               end else if (m0_readDataValid) begin
                  // Zero-latency slave: data arrives alongside command acceptance.
                  rdata_d = m0_readData;
                  state_d = ST_RSP;
               end else begin
                  state_d = ST_RDWAIT;
               end
            end
         end
         ST_RDWAIT: begin
            if (m0_readDataValid) begin
               rdata_d = m0_readData;
               state_d = ST_RSP;
            end else if (tmo_expired) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = ST_RSP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rest) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
`ifdef CACHE_IO_CFG_TIMEOUT_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         write_q <= write_d;
         rdata_q <= rdata_d;
`ifdef CACHE_IO_CFG_TIMEOUT_EN
         err_q   <= err_d;
`endif
      end
   end

   // Strobes are decoded from state so read and write can never overlap.
   assign req_ready     = (state_q == ST_IDLE);
   assign m0_read       = (state_q == ST_CMD) && !write_q;
   assign m0_write      = (state_q == ST_CMD) && write_q;
   assign m0_address    = addr_q;
   assign m0_byteEnable = be_q;
   assign m0_writeData  = wdata_q;
   assign rsp_valid     = (state_q == ST_RSP);
   assign rsp_write     = (state_q == ST_RSP) && write_q;
   assign rsp_rdata     = rdata_q;

endmodule
